// File: rtl/auc_encoder_pkg.sv
// Shared definitions for the AUC command decoder and result encoder:
// operand RAM address map, function-unit mode codes and encoder FSM states.
package auc_encoder_pkg;

    localparam logic [4:0] X_G   = 5'd0;
    localparam logic [4:0] K_NUM = 5'd11;
    localparam logic [4:0] K_INV = 5'd12;
    localparam logic [4:0] R_NUM = 5'd13;
    localparam logic [4:0] S_NUM = 5'd14;
    localparam logic [4:0] X_KG  = 5'd15;
    localparam logic [4:0] BLNK  = 5'd31;

    typedef enum logic [2:0] {
        MODE_RAND = 3'b000,
        MODE_INVS = 3'b001,
        MODE_R    = 3'b010,
        MODE_S    = 3'b011,
        MODE_MMUL = 3'b101
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_SEND = 2'd3
    } enc_state_t;

endpackage

// File: rtl/auc_enc_addrgen.sv
// Result word lists per mode: (mode, word index) -> RAM address, frame length - 1.
module auc_enc_addrgen
    import auc_encoder_pkg::*;
#(
    parameter int ADDR = 5
) (
    input  mode_t           mode_i,
    input  logic            wcnt_i,
    output logic [ADDR-1:0] addr_o,
    output logic            wlen_o
);

    always_comb begin
        addr_o = ADDR'(BLNK);
        wlen_o = 1'b0;
        unique case (mode_i)
            MODE_RAND: addr_o = ADDR'(K_NUM);
            MODE_INVS: addr_o = ADDR'(K_INV);
            MODE_R:    addr_o = ADDR'(R_NUM);
            MODE_S: begin
                addr_o = wcnt_i ? ADDR'(S_NUM) : ADDR'(R_NUM);
                wlen_o = 1'b1;
            end
            MODE_MMUL: addr_o = ADDR'(X_KG);
            default:   addr_o = ADDR'(BLNK);
        endcase
    end

endmodule

// File: rtl/fflopx.sv
// Load-enabled register with asynchronous active-low clear.
module fflopx #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q_o <= '0;
        else if (en_i)
            q_o <= d_i;
    end

endmodule

// File: rtl/auc_encoder.sv
// AUC result encoder: on a function-unit done pulse, reads that unit's result
// words from the operand RAM and streams them to the host as one framed burst.
module auc_encoder
    import auc_encoder_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int ADDR  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             done_rand,
    input  logic             done_invs,
    input  logic             done_r,
    input  logic             done_s,
    input  logic             done_mmul,
    output logic             enc_ren,
    output logic [ADDR-1:0]  enc_radd,
    input  logic [WIDTH-1:0] enc_rdat,
    output logic [WIDTH-1:0] enc_dat,
    output logic             enc_vld,
    input  logic             enc_rdy,
    output logic             enc_start,
    output logic             enc_last,
    output logic [2:0]       enc_mode,
    output logic             enc_busy,
    output logic             enc_drop
);

    enc_state_t      state_q, state_d;
    mode_t           mode_q, mode_d;
    logic            wcnt_q, wcnt_d;
    logic            wlen_q, wlen_d;
    logic            last_q, last_d;
    logic            start_q, start_d;
    logic            drop_q, drop_d;
    logic            dat_load;
    logic            done_any, done_multi;
    mode_t           sel_mode, gen_mode;
    logic [ADDR-1:0] gen_addr;
    logic            gen_wlen;

    assign done_any   = done_s | done_r | done_invs | done_mmul | done_rand;
    assign done_multi = $countones({done_s, done_r, done_invs, done_mmul, done_rand}) > 1;

    always_comb begin
        if (done_s)         sel_mode = MODE_S;
        else if (done_r)    sel_mode = MODE_R;
        else if (done_invs) sel_mode = MODE_INVS;
        else if (done_mmul) sel_mode = MODE_MMUL;
        else                sel_mode = MODE_RAND;
    end

    // In IDLE the generator looks at the incoming mode so wlen can be latched at frame start.
    assign gen_mode = (state_q == ST_IDLE) ? sel_mode : mode_q;

    auc_enc_addrgen #(.ADDR(ADDR)) u_addrgen (
        .mode_i (gen_mode),
        .wcnt_i (wcnt_q),
        .addr_o (gen_addr),
        .wlen_o (gen_wlen)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        wcnt_d   = wcnt_q;
        wlen_d   = wlen_q;
        last_d   = last_q;
        start_d  = start_q;
        drop_d   = done_any;
        dat_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                drop_d = done_multi;
                if (done_any) begin
                    mode_d  = sel_mode;
                    wcnt_d  = 1'b0;
                    wlen_d  = gen_wlen;
                    start_d = 1'b1;
                    state_d = ST_RD;
                end
            end
            ST_RD: state_d = ST_CAP;
            ST_CAP: begin
                dat_load = 1'b1;
                last_d   = (wcnt_q == wlen_q);
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (enc_rdy) begin
                    if (wcnt_q == wlen_q) begin
                        start_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        wcnt_d  = wcnt_q + 1'b1;
                        state_d = ST_RD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_RAND;
            wcnt_q  <= 1'b0;
            wlen_q  <= 1'b0;
            last_q  <= 1'b0;
            start_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            wcnt_q  <= wcnt_d;
            wlen_q  <= wlen_d;
            last_q  <= last_d;
            start_q <= start_d;
            drop_q  <= drop_d;
        end
    end

    fflopx #(.W(WIDTH)) u_dat_reg (
        .clk   (clk),
        .rst_n (rst),
        .en_i  (dat_load),
        .d_i   (enc_rdat),
        .q_o   (enc_dat)
    );

    assign enc_ren   = (state_q == ST_RD);
    assign enc_radd  = enc_ren ? gen_addr : ADDR'(BLNK);
    assign enc_vld   = (state_q == ST_SEND);
    assign enc_busy  = (state_q != ST_IDLE);
    assign enc_start = start_q;
    assign enc_last  = last_q;
    assign enc_mode  = mode_q;
    assign enc_drop  = drop_q;

endmodule

// File: tb/tb_auc_encoder.sv
// Directed bench for auc_encoder with a queue scoreboard on host transfers.
module tb_auc_encoder;

    localparam int WIDTH = 256;
    localparam int ADDR  = 5;

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic             last;
        logic [2:0]       mode;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             done_rand = 1'b0, done_invs = 1'b0, done_r = 1'b0;
    logic             done_s = 1'b0, done_mmul = 1'b0;
    logic             enc_ren;
    logic [ADDR-1:0]  enc_radd;
    logic [WIDTH-1:0] enc_rdat = '0;
    logic [WIDTH-1:0] enc_dat;
    logic             enc_vld;
    logic             enc_rdy = 1'b0;
    logic             enc_start, enc_last, enc_busy, enc_drop;
    logic [2:0]       enc_mode;

    logic [WIDTH-1:0] mem [32];
    exp_t             sb[$];
    int               vec_cnt = 0;
    int               err_cnt = 0;

    auc_encoder #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
        .clk(clk), .rst(rst),
        .done_rand(done_rand), .done_invs(done_invs), .done_r(done_r),
        .done_s(done_s), .done_mmul(done_mmul),
        .enc_ren(enc_ren), .enc_radd(enc_radd), .enc_rdat(enc_rdat),
        .enc_dat(enc_dat), .enc_vld(enc_vld), .enc_rdy(enc_rdy),
        .enc_start(enc_start), .enc_last(enc_last), .enc_mode(enc_mode),
        .enc_busy(enc_busy), .enc_drop(enc_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (enc_ren) enc_rdat <= mem[enc_radd];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens on the next edge whenever vld & rdy are seen here.
    always @(negedge clk) begin
        if (rst && enc_vld && enc_rdy) begin
            if (sb.size() == 0) begin
                check("unexpected_word", WIDTH'(enc_mode), '1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("xfer_dat", enc_dat, e.dat);
                check("xfer_last", WIDTH'(enc_last), WIDTH'(e.last));
                check("xfer_mode", WIDTH'(enc_mode), WIDTH'(e.mode));
                check("xfer_start", WIDTH'(enc_start), WIDTH'(1'b1));
            end
        end
    end

    // bits: {mmul, s, r, invs, rand}; returns 1ns after the sampling edge
    task automatic pulse(input logic [4:0] m);
        @(posedge clk); #1;
        {done_mmul, done_s, done_r, done_invs, done_rand} = m;
        @(posedge clk); #1;
        {done_mmul, done_s, done_r, done_invs, done_rand} = 5'b0;
    endtask

    task automatic wait_idle(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!enc_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", WIDTH'(ok), WIDTH'(1'b1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = WIDTH'(i) * 256'h0101_0101;
        mem[13] = {32{8'hA5}};
        mem[15] = {16'hDEAD, 224'h0, 16'hBEEF};
        mem[12] = {8{32'h1234_5678}};

        // Reset held with activity on the inputs
        enc_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            {done_mmul, done_s, done_r, done_invs, done_rand} = 5'($urandom);
            @(negedge clk);
            check("rst_ren", WIDTH'(enc_ren), '0);
            check("rst_radd", WIDTH'(enc_radd), WIDTH'(31));
            check("rst_outs", WIDTH'({enc_vld, enc_start, enc_last, enc_busy, enc_drop, enc_mode}), '0);
        end
        check("rst_dat", enc_dat, '0);
        {done_mmul, done_s, done_r, done_invs, done_rand} = 5'b0;
        @(negedge clk); rst = 1'b1;

        // Single word R
        sb.push_back('{dat: {32{8'hA5}}, last: 1'b1, mode: 3'b010});
        pulse(5'b00100);
        @(negedge clk);
        check("r_ren", WIDTH'(enc_ren), WIDTH'(1'b1));
        check("r_radd", WIDTH'(enc_radd), WIDTH'(13));
        @(negedge clk);
        check("r_cap_vld", WIDTH'(enc_vld), '0);
        check("r_cap_radd", WIDTH'(enc_radd), WIDTH'(31));
        @(negedge clk);
        check("r_vld", WIDTH'({enc_vld, enc_last, enc_mode}), WIDTH'(5'b11010));
        check("r_dat", enc_dat, {32{8'hA5}});
        @(negedge clk);
        check("r_end", WIDTH'({enc_vld, enc_start, enc_busy, enc_last}), '0);

        // S pair with host stall
        mem[13] = 256'h1;
        mem[14] = 256'h2;
        enc_rdy = 1'b0;
        sb.push_back('{dat: 256'h1, last: 1'b0, mode: 3'b011});
        sb.push_back('{dat: 256'h2, last: 1'b1, mode: 3'b011});
        pulse(5'b01000);
        @(negedge clk);
        check("s_radd0", WIDTH'(enc_radd), WIDTH'(13));
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s_stall_dat", enc_dat, 256'h1);
            check("s_stall_ctl", WIDTH'({enc_vld, enc_last, enc_start}), WIDTH'(3'b101));
        end
        enc_rdy = 1'b1;
        @(negedge clk);
        check("s_radd1", WIDTH'({enc_ren, enc_radd}), WIDTH'({1'b1, 5'd14}));
        check("s_start_mid", WIDTH'(enc_start), WIDTH'(1'b1));
        @(negedge clk);
        check("s_gap_vld", WIDTH'(enc_vld), '0);
        @(negedge clk);
        check("s_w1", WIDTH'({enc_vld, enc_last, enc_dat[7:0]}), WIDTH'({2'b11, 8'h02}));
        @(negedge clk);
        check("s_end", WIDTH'({enc_start, enc_busy}), '0);

        // Collision: S beats RAND; MMUL during SEND is dropped
        enc_rdy = 1'b0;
        sb.push_back('{dat: 256'h1, last: 1'b0, mode: 3'b011});
        sb.push_back('{dat: 256'h2, last: 1'b1, mode: 3'b011});
        pulse(5'b01001);
        @(negedge clk);
        check("col_drop", WIDTH'(enc_drop), WIDTH'(1'b1));
        check("col_mode", WIDTH'(enc_mode), WIDTH'(3'b011));
        @(negedge clk);
        check("col_drop_off", WIDTH'(enc_drop), '0);
        @(negedge clk);
        pulse(5'b10000);
        @(negedge clk);
        check("send_drop", WIDTH'({enc_drop, enc_vld}), WIDTH'(2'b11));
        @(negedge clk);
        check("send_drop_off", WIDTH'(enc_drop), '0);
        enc_rdy = 1'b1;
        wait_idle(20);
        repeat (4) @(negedge clk);
        check("no_mmul_frame", WIDTH'({enc_busy, enc_ren}), '0);

        // MMUL
        sb.push_back('{dat: {16'hDEAD, 224'h0, 16'hBEEF}, last: 1'b1, mode: 3'b101});
        pulse(5'b10000);
        @(negedge clk);
        check("mmul_radd", WIDTH'(enc_radd), WIDTH'(15));
        @(negedge clk);
        @(negedge clk);
        check("mmul_mode", WIDTH'(enc_mode), WIDTH'(3'b101));
        wait_idle(20);

        // Reset mid-frame
        enc_rdy = 1'b0;
        pulse(5'b01000);
        repeat (3) @(negedge clk);
        check("abort_pre", WIDTH'(enc_vld), WIDTH'(1'b1));
        rst = 1'b0;
        #1;
        check("abort_async", WIDTH'({enc_vld, enc_start, enc_busy, enc_last}), '0);
        check("abort_dat", enc_dat, '0);
        @(negedge clk); rst = 1'b1;
        enc_rdy = 1'b1;
        sb.push_back('{dat: {8{32'h1234_5678}}, last: 1'b1, mode: 3'b001});
        pulse(5'b00010);
        @(negedge clk);
        check("invs_radd", WIDTH'({enc_ren, enc_radd}), WIDTH'({1'b1, 5'd12}));
        wait_idle(20);

        repeat (2) @(negedge clk);
        check("sb_empty", WIDTH'(sb.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/auc_encoder.md
Name: auc_encoder

Overview:
- Return-path counterpart of the AUC command decoder.
- When a function unit (rand, invs, r, s, mmul) signals completion, the block reads the result words from the shared operand RAM and streams them to the host.
- The stream is a framed valid/ready word stream, with a frame-active strobe that mirrors the host-to-core auc_start framing.
- Sits between the function units' done pulses, the RAM read port and the host AUC interface.

Parameters:
- WIDTH, 256: data word width, equal to the RAM word width.
- ADDR, 5: RAM address width.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- done_rand  in  1  one-cycle pulse: rand finished.
- done_invs  in  1  one-cycle pulse: invs finished.
- done_r  in  1  one-cycle pulse: r finished.
- done_s  in  1  one-cycle pulse: s finished.
- done_mmul  in  1  one-cycle pulse: mmul finished.
- enc_ren  out  1  RAM read enable.
- enc_radd  out  ADDR  RAM read address.
- enc_rdat  in  WIDTH  RAM read data, valid exactly 1 cycle after enc_ren.
- enc_dat  out  WIDTH  word to host.
- enc_vld  out  1  enc_dat valid.
- enc_rdy  in  1  host accepts enc_dat.
- enc_start  out  1  frame active (result stream in progress).
- enc_last  out  1  qualifies the final word of the frame.
- enc_mode  out  3  mode code of the current frame (decoder encoding).
- enc_busy  out  1  frame in progress (IDLE not current).
- enc_drop  out  1  one-cycle pulse: done pulse ignored because busy.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs are 0, except enc_radd=31 (BLNK) and enc_mode=3'b000.
- Mode codes are shared with the decoder: RAND=000, INVS=001, R=010, S=011, MMUL=101.
- Result address lists, in output order:
  - RAND -> {11 K_NUM}
  - INVS -> {12 K_INV}
  - R -> {13 R_NUM}
  - S -> {13 R_NUM, 14 S_NUM}
  - MMUL -> {15 X_KG}
- Done-pulse priority when several are sampled in the same IDLE cycle: s > r > invs > mmul > rand. Lower-priority simultaneous pulses are dropped, with one enc_drop pulse.
- Any done pulse sampled outside IDLE is dropped. enc_drop=1 in the following cycle; the frame in progress is unaffected.
- A 1-bit word index counter wcnt and a 1-bit length register wlen (words-1) are latched at frame start.
- FSM:
  - IDLE: on a done pulse, latch mode, wcnt=0 and wlen. Go to RD.
  - RD: enc_ren=1 for one cycle, enc_radd=list[wcnt]. Go to CAP.
  - CAP: load enc_dat<=enc_rdat and set enc_vld=1. enc_last=(wcnt==wlen). Go to SEND.
  - SEND: hold enc_dat, enc_vld and enc_last stable until enc_rdy=1 at a rising edge (the transfer), then clear enc_vld.
    - If wcnt==wlen: go to IDLE, with enc_start, enc_last and enc_busy cleared on the same edge.
    - Else: wcnt+1 and go to RD.
- enc_start is set on the edge that leaves IDLE and stays high through the last transfer. enc_busy equals state!=IDLE.
- Latency:
  - Done pulse at edge n -> enc_ren high in cycle n+1 -> enc_vld high from edge n+3.
  - Each subsequent word arrives 2 cycles after the previous transfer.
- enc_rdy is ignored while enc_vld=0. enc_rdy held high gives back-to-back frames with the minimum gap above.
- enc_ren=0 and enc_radd=31 whenever the state is not RD.
- enc_dat keeps its last value after a frame. It is only meaningful while enc_vld=1.
- Reset mid-frame: immediate abort to the reset values. No partial completion is signalled.
- There is no timeout; host stall in SEND holds indefinitely.

Decomposition:
- Shared package/include holds:
  - the RAM address localparams (X_G..BLNK), so decoder and encoder share one map;
  - the mode codes RAND/INVS/R/S/MMUL;
  - the FSM state encoding.
- One sub-module, auc_enc_addrgen: combinational mapping of (mode, wcnt) -> (read address, wlen). Keeps the result lists in one editable place.
- Output data register uses the existing fflopx with load enable logic in the parent.

Test Plan:
- Reset: hold rst=0 with enc_rdy=1 and done pulses toggling -> every output at its reset value; enc_radd=31; no enc_ren.
- Single word: pulse done_r with RAM[13]=0xA5..A5 and enc_rdy=1 -> enc_ren with enc_radd=13 one cycle after the pulse. Three cycles after the pulse: enc_vld=1, enc_last=1, enc_dat=0xA5..A5, enc_mode=010. The frame ends after one transfer.
- S pair with stall: RAM[13]=0x1, RAM[14]=0x2, pulse done_s, enc_rdy=0 for 5 cycles then 1 -> word 0x1 held stable with enc_last=0. Then 0x2 with enc_last=1 arrives 2 cycles after the first transfer. enc_start is high across both words.
- Collision: pulse done_s and done_rand in the same cycle -> the S frame runs; enc_drop=1 for one cycle. Pulse done_mmul during SEND -> enc_drop=1 and no MMUL frame follows.
- MMUL: RAM[15]=0xDEAD..BEEF, pulse done_mmul -> one word 0xDEAD..BEEF, enc_mode=101, enc_radd=15.
- Reset mid-frame: assert rst=0 in SEND of S word 0 -> enc_vld, enc_start and enc_busy drop asynchronously. After release the block is IDLE and accepts a new done_invs, reading address 12.
